// File: rtl/reg_file_pkg.sv
// Shared definitions for the general-purpose register file.
// Reserved register indices and default widths live here.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_idx_t;
  typedef logic [DATA_W_DEFAULT-1:0] data_word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: forces register 0 to zero and, when
// REG_FILE_BYPASS_EN is defined, forwards same-cycle write data.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic rd_zero;
  assign rd_zero = (raddr_i == ADDR_W'(REG_ZERO));

`ifdef REG_FILE_BYPASS_EN
  logic fwd_hit;
  assign fwd_hit = we_i && (waddr_i != ADDR_W'(REG_ZERO)) && (waddr_i == raddr_i);

  always_comb begin
    rdata_o = stored_i;
    if (rd_zero) begin
      rdata_o = '0;
    end else if (fwd_hit) begin
      rdata_o = wdata_i;
    end
  end
`else
  // Write-port inputs only matter when forwarding is compiled in.
  logic unused_wr;
  assign unused_wr = ^{we_i, waddr_i, wdata_i};

  always_comb begin
    rdata_o = stored_i;
    if (rd_zero) begin
      rdata_o = '0;
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file: two combinational read ports, one synchronous write
// port, register 0 hardwired to zero. Optional bypass via REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREG = 2**ADDR_W;

  // Entry 0 has no storage; the read view below supplies its constant zero.
  logic [DATA_W-1:0] mem_q [1:NREG-1];
  logic [DATA_W-1:0] words [NREG];
  logic              wr_en;

  assign wr_en = we && (waddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    words[0] = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      words[i] = mem_q[i];
    end
  end

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .raddr_i  (raddr1),
    .stored_i (words[raddr1]),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .rdata_o  (rdata1)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .raddr_i  (raddr2),
    .stored_i (words[raddr2]),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .rdata_o  (rdata2)
  );

  assign dbg_data = words[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file with an expected-value scoreboard.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, waddr, dbg_addr;
  logic [31:0] rdata1, rdata2, wdata, dbg_data;
  logic        we;

  logic [31:0] sb[$];
  logic [31:0] model [32];
  int unsigned checks;
  int unsigned errors;

  reg_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      exp_v = sb.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  // Push expectations for all three read ports, drive indices, then compare.
  task automatic rd3(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] ad, input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] ed);
    sb.push_back(e1);
    sb.push_back(e2);
    sb.push_back(ed);
    raddr1 = a1; raddr2 = a2; dbg_addr = ad;
    #1;
    chk({tag, "_rd1"}, rdata1);
    chk({tag, "_rd2"}, rdata2);
    chk({tag, "_dbg"}, dbg_data);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  initial begin
    logic [31:0] exp_raw;
    checks = 0; errors = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = '0; raddr2 = '0; dbg_addr = '0;

    // Reset values
    @(negedge clk);
    rd3("reset", 5'd5, 5'd31, 5'd1, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Asynchronous reset clears stored data without a clock edge
    wr(5'd5, 32'h1234_5678);
    rd3("pre_rst", 5'd5, 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    #1 rst_n = 1'b0;
    rd3("async_rst", 5'd5, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Write held across an edge while in reset is dropped
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; waddr = 5'd10; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    rd3("wr_in_rst", 5'd10, 5'd10, 5'd10, 32'h0, 32'h0, 32'h0);

    // Basic write/read
    wr(5'd3, 32'hDEAD_BEEF);
    rd3("basic", 5'd3, 5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Zero register: write discarded, never forwarded
    wr(5'd0, 32'hFFFF_FFFF);
    rd3("zero", 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    rd3("zero_fwd", 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    we = 1'b0;

    // Same-cycle read-after-write
    wr(5'd7, 32'h0000_0011);
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0022;
`ifdef REG_FILE_BYPASS_EN
    exp_raw = 32'h0000_0022;
`else
    exp_raw = 32'h0000_0011;
`endif
    rd3("raw_same", 5'd3, 5'd7, 5'd7, 32'hDEAD_BEEF, exp_raw, 32'h0000_0011);
    @(negedge clk);
    we = 1'b0;
    model[7] = 32'h0000_0022;
    rd3("raw_after", 5'd7, 5'd7, 5'd7, 32'h22, 32'h22, 32'h22);

    // we=0 hold
    @(negedge clk);
    we = 1'b0; waddr = 5'd9; wdata = 32'hAAAA_AAAA;
    repeat (3) @(negedge clk);
    rd3("we0_hold", 5'd9, 5'd9, 5'd9, model[9], model[9], model[9]);

    // Full sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      rd3($sformatf("sweep%0d", i), 5'(i), 5'(31 - i), 5'(i),
          (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101, model[31 - i], model[i]);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
